// File: rtl/tx_char_sequencer_pkg.sv
// Shared ISO7816 transmit-side definitions: sequencer state encodings and defaults.
package tx_char_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    GUARD = 3'd3,
    HALT  = 3'd4,
    DRAIN = 3'd5
  } seqState_t;

  localparam int         ETU_DEFAULT         = 372;
  localparam logic [2:0] RETRY_LIMIT_DEFAULT = 3'd4;

  // A character may already be owned by the transmit core in these states.
  function automatic logic flushToDrain(input seqState_t s);
    return (s == LOAD) || (s == SEND) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/tx_char_sequencer_if.sv
// Load handshake and frame status between the sequencer (master) and the transmit core (slave).
interface tx_char_sequencer_if;
  logic [7:0] txData;
  logic       txLoad;
  logic       txFull;
  logic       txRun;
  logic       txStopBits;

  modport master (output txData, txLoad, input txFull, txRun, txStopBits);
  modport slave  (input txData, txLoad, output txFull, txRun, txStopBits);
endinterface

// File: rtl/tx_byte_fifo.sv
// Byte FIFO with flush; write visible at head the cycle after wrEn, level counts stored entries.
// Writes while full are dropped; flush wins over a simultaneous write or pop.
module tx_byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                flush,
  input  logic [7:0]          wrData,
  input  logic                wrEn,
  input  logic                pop,
  output logic [7:0]          headData,
  output logic                full,
  output logic [DEPTH_LOG2:0] level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  push;
  logic                  popOk;

  assign push     = wrEn & ~full & ~flush;
  assign popOk    = pop & (level != '0) & ~flush;
  assign full     = level[DEPTH_LOG2];
  assign headData = mem[rdPtr];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + DEPTH_LOG2'(1);
      end
      if (popOk) rdPtr <= rdPtr + DEPTH_LOG2'(1);
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else if (push && !popOk) begin
        level <= level + (DEPTH_LOG2 + 1)'(1);
      end else if (popOk && !push) begin
        level <= level - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end
endmodule

// File: rtl/tx_char_sequencer.sv
// Feeds queued bytes to the ISO7816 transmit core with extra guard time and T=0 retransmission.
// txLoad two cycles after a write into an idle, empty queue; holds txLoad until the core raises txFull.
module tx_char_sequencer
  import tx_char_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2     = 3,
  parameter int CLOCK_PER_BIT_WIDTH = 13,
  parameter int GUARD_WIDTH         = 8
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic [7:0]                     wrData,
  input  logic                           wrEn,
  output logic                           wrFull,
  output logic [FIFO_DEPTH_LOG2:0]       wrLevel,
  input  logic                           flush,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic [GUARD_WIDTH-1:0]         guardEtu,
  input  logic                           errorDetectEn,
  input  logic [2:0]                     retryLimit,
  input  logic                           ioIn,
  tx_char_sequencer_if.master            tx,
  output logic                           busy,
  output logic                           charDone,
  output logic                           txError
);
  localparam logic [CLOCK_PER_BIT_WIDTH-1:0] CLK_ONE = CLOCK_PER_BIT_WIDTH'(1);
  localparam logic [GUARD_WIDTH-1:0]         ETU_ONE = GUARD_WIDTH'(1);

  seqState_t                      state;
  logic [7:0]                     headData;
  logic                           loadReq;
  logic                           stopPrev;
  logic                           runPrev;
  logic                           sampling;
  logic                           errFlag;
  logic [2:0]                     retryCnt;
  logic [CLOCK_PER_BIT_WIDTH-1:0] clkCnt;
  logic [GUARD_WIDTH-1:0]         etuCnt;
  logic                           guardDone;
  logic                           popHead;

  assign guardDone = (etuCnt >= guardEtu);
  // Pop on the same edge that pulses charDone so IDLE never sees a stale level.
  assign popHead   = (state == GUARD) & guardDone & ~errFlag;

  tx_byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) fifo (
    .clk      (clk),
    .nReset   (nReset),
    .flush    (flush),
    .wrData   (wrData),
    .wrEn     (wrEn),
    .pop      (popHead),
    .headData (headData),
    .full     (wrFull),
    .level    (wrLevel)
  );

  assign tx.txData = headData;
  assign tx.txLoad = loadReq;
  assign busy      = (state != IDLE) | (wrLevel != '0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      loadReq  <= 1'b0;
      charDone <= 1'b0;
      txError  <= 1'b0;
      retryCnt <= 3'd0;
      errFlag  <= 1'b0;
      sampling <= 1'b0;
      clkCnt   <= '0;
      etuCnt   <= '0;
      stopPrev <= 1'b0;
      runPrev  <= 1'b0;
    end else begin
      stopPrev <= tx.txStopBits;
      runPrev  <= tx.txRun;
      charDone <= 1'b0;
      if (flush) begin
        state    <= flushToDrain(state) ? DRAIN : IDLE;
        loadReq  <= 1'b0;
        txError  <= 1'b0;
        retryCnt <= 3'd0;
        errFlag  <= 1'b0;
        sampling <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (wrLevel != '0 && !txError) begin
              state   <= LOAD;
              loadReq <= 1'b1;
            end
          end
          LOAD: begin
            if (tx.txFull) begin
              state    <= SEND;
              loadReq  <= 1'b0;
              sampling <= 1'b0;
            end
          end
          SEND: begin
            // The receiver's error signal is checked 1 ETU into the stop bits (11 ETU from start).
            if (sampling) begin
              if (clkCnt == clocksPerBit) begin
                errFlag  <= errorDetectEn & ~ioIn;
                sampling <= 1'b0;
              end else begin
                clkCnt <= clkCnt + CLK_ONE;
              end
            end
            if (tx.txStopBits && !stopPrev) begin
              sampling <= 1'b1;
              clkCnt   <= CLK_ONE;
            end
            if (runPrev && !tx.txRun) begin
              state    <= GUARD;
              sampling <= 1'b0;
              clkCnt   <= '0;
              etuCnt   <= '0;
            end
          end
          GUARD: begin
            if (guardDone) begin
              clkCnt <= '0;
              etuCnt <= '0;
              if (!errFlag) begin
                charDone <= 1'b1;
                retryCnt <= 3'd0;
                state    <= IDLE;
              end else if (retryCnt < retryLimit) begin
                retryCnt <= retryCnt + 3'd1;
                errFlag  <= 1'b0;
                loadReq  <= 1'b1;
                state    <= LOAD;
              end else begin
                txError <= 1'b1;
                state   <= HALT;
              end
            end else if (clkCnt == clocksPerBit - CLK_ONE) begin
              clkCnt <= '0;
              etuCnt <= etuCnt + ETU_ONE;
            end else begin
              clkCnt <= clkCnt + CLK_ONE;
            end
          end
          HALT: state <= HALT;
          DRAIN: begin
            if (!tx.txRun && !tx.txFull) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_char_sequencer.sv
// Directed bench for tx_char_sequencer with a behavioural transmit core (12 ETU frame, stop bits at 10 ETU).
module tb_tx_char_sequencer;
  import tx_char_sequencer_pkg::*;

  logic        clk;
  logic        nReset;
  logic [7:0]  wrData;
  logic        wrEn;
  logic        wrFull;
  logic [3:0]  wrLevel;
  logic        flush;
  logic [12:0] clocksPerBit;
  logic [7:0]  guardEtu;
  logic        errorDetectEn;
  logic [2:0]  retryLimit;
  logic        ioIn;
  logic        busy;
  logic        charDone;
  logic        txError;

  tx_char_sequencer_if txIf ();

  tx_char_sequencer dut (
    .clk           (clk),
    .nReset        (nReset),
    .wrData        (wrData),
    .wrEn          (wrEn),
    .wrFull        (wrFull),
    .wrLevel       (wrLevel),
    .flush         (flush),
    .clocksPerBit  (clocksPerBit),
    .guardEtu      (guardEtu),
    .errorDetectEn (errorDetectEn),
    .retryLimit    (retryLimit),
    .ioIn          (ioIn),
    .tx            (txIf),
    .busy          (busy),
    .charDone      (charDone),
    .txError       (txError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vecCnt = 0;
  int         missCnt = 0;
  logic [7:0] sentQ[$];
  int         acceptCyc[$];
  int         doneCnt = 0;
  int         cyc = 0;
  int         errIdx = -1;
  bit         errAll = 1'b0;

  task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      missCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmit core model: accepts on txLoad, runs 12 ETU, stop bits from 10 ETU.
  // A rejected frame has ioIn pulled low from 10.5 to 11.5 ETU.
  initial begin
    int  mT;
    int  mCpb;
    bit  mBusy;
    bit  mAccept;
    bit  mCorrupt;
    txIf.txFull = 1'b0; txIf.txRun = 1'b0; txIf.txStopBits = 1'b0; ioIn = 1'b1;
    mT = 0; mCpb = 1; mBusy = 1'b0; mAccept = 1'b0; mCorrupt = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (charDone) doneCnt++;
      if (!nReset) begin
        txIf.txFull = 1'b0; txIf.txRun = 1'b0; txIf.txStopBits = 1'b0; ioIn = 1'b1;
        mBusy = 1'b0; mAccept = 1'b0;
      end else if (mAccept) begin
        txIf.txFull = 1'b0; txIf.txRun = 1'b1; mT = 0; mAccept = 1'b0; mBusy = 1'b1;
      end else if (mBusy) begin
        mT++;
        if (mT == 10 * mCpb) txIf.txStopBits = 1'b1;
        ioIn = !(mCorrupt && (2 * mT >= 21 * mCpb) && (2 * mT < 23 * mCpb));
        if (mT == 12 * mCpb) begin
          txIf.txRun = 1'b0; txIf.txStopBits = 1'b0; ioIn = 1'b1; mBusy = 1'b0;
        end
      end else if (txIf.txLoad) begin
        mCorrupt = errAll || (sentQ.size() == errIdx);
        sentQ.push_back(txIf.txData);
        acceptCyc.push_back(cyc);
        mCpb = int'(clocksPerBit);
        txIf.txFull = 1'b1; mAccept = 1'b1;
      end
    end
  end

  task automatic waitIdle(input string tag, input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin @(negedge clk); k++; end
    checkVec(tag, busy, 1'b0);
  endtask

  task automatic waitState(input string tag, input seqState_t st, input int limit);
    int k;
    k = 0;
    while (dut.state != st && k < limit) begin @(negedge clk); k++; end
    checkVec(tag, dut.state, st);
  endtask

  initial begin
    int sBase;
    int dBase;
    nReset = 1'b0; wrData = 8'h00; wrEn = 1'b0; flush = 1'b0;
    clocksPerBit = 13'd4; guardEtu = 8'd0; errorDetectEn = 1'b0;
    retryLimit = RETRY_LIMIT_DEFAULT;
    repeat (3) @(negedge clk);
    checkVec("rst txLoad", txIf.txLoad, 1'b0);
    checkVec("rst txData", txIf.txData, 8'h00);
    checkVec("rst wrLevel/wrFull", {wrFull, wrLevel}, 5'd0);
    checkVec("rst busy/charDone/txError", {busy, charDone, txError}, 3'd0);
    checkVec("rst state", dut.state, IDLE);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Three bytes, no guard, no error checking; also write-to-load latency.
    sBase = sentQ.size(); dBase = doneCnt;
    wrData = 8'h3B; wrEn = 1'b1;
    @(negedge clk);
    checkVec("lat t+1 txLoad", txIf.txLoad, 1'b0);
    checkVec("lat head txData", txIf.txData, 8'h3B);
    wrData = 8'h00;
    @(negedge clk);
    checkVec("lat t+2 txLoad", txIf.txLoad, 1'b1);
    wrData = 8'hFF;
    @(negedge clk);
    wrEn = 1'b0;
    checkVec("three level", wrLevel, 4'd3);
    waitIdle("three idle", 1000);
    checkVec("three sent", sentQ.size() - sBase, 3);
    checkVec("three byte0", sentQ[sBase], 8'h3B);
    checkVec("three byte1", sentQ[sBase + 1], 8'h00);
    checkVec("three byte2", sentQ[sBase + 2], 8'hFF);
    checkVec("three charDone", doneCnt - dBase, 3);
    checkVec("three level end", wrLevel, 4'd0);
    // 12 ETU frame + accept cycle + fall detect + guard decision + IDLE = 48 + 4
    checkVec("spacing g0", acceptCyc[sBase + 1] - acceptCyc[sBase], 52);

    // Guard time at the default ETU.
    clocksPerBit = 13'(ETU_DEFAULT); guardEtu = 8'd2;
    sBase = sentQ.size(); dBase = doneCnt;
    wrData = 8'hA5; wrEn = 1'b1; @(negedge clk);
    wrData = 8'h5A; @(negedge clk);
    wrEn = 1'b0;
    waitIdle("guard idle", 15000);
    checkVec("guard sent", sentQ.size() - sBase, 2);
    checkVec("guard byte1", sentQ[sBase + 1], 8'h5A);
    checkVec("guard charDone", doneCnt - dBase, 2);
    checkVec("spacing g2", acceptCyc[sBase + 1] - acceptCyc[sBase], 12 * 372 + 744 + 4);

    // One rejected frame: same byte resent once, one charDone.
    clocksPerBit = 13'd4; guardEtu = 8'd1; errorDetectEn = 1'b1;
    sBase = sentQ.size(); dBase = doneCnt;
    errIdx = sBase;
    wrData = 8'hC3; wrEn = 1'b1; @(negedge clk);
    wrEn = 1'b0;
    waitIdle("retry idle", 2000);
    errIdx = -1;
    checkVec("retry sent", sentQ.size() - sBase, 2);
    checkVec("retry resend byte", sentQ[sBase + 1], 8'hC3);
    checkVec("retry charDone", doneCnt - dBase, 1);
    checkVec("retry count cleared", dut.retryCnt, 3'd0);
    checkVec("retry txError", txError, 1'b0);

    // Every frame rejected with retryLimit=2: three transmissions then HALT.
    retryLimit = 3'd2; errAll = 1'b1;
    sBase = sentQ.size(); dBase = doneCnt;
    wrData = 8'h96; wrEn = 1'b1; @(negedge clk);
    wrEn = 1'b0;
    waitState("halt reached", HALT, 2000);
    repeat (30) @(negedge clk);
    checkVec("halt sent", sentQ.size() - sBase, 3);
    checkVec("halt byte", sentQ[sBase + 2], 8'h96);
    checkVec("halt txError", txError, 1'b1);
    checkVec("halt busy/level", {busy, wrLevel}, {1'b1, 4'd1});
    checkVec("halt charDone", doneCnt - dBase, 0);
    errAll = 1'b0;
    flush = 1'b1; @(negedge clk);
    flush = 1'b0;
    checkVec("halt flush state", dut.state, IDLE);
    checkVec("halt flush level/err", {wrLevel, txError, busy}, 6'd0);

    // Nine writes into eight entries.
    errorDetectEn = 1'b0; retryLimit = RETRY_LIMIT_DEFAULT;
    sBase = sentQ.size(); dBase = doneCnt;
    for (int i = 0; i < 9; i++) begin
      wrData = 8'h10 + 8'(i); wrEn = 1'b1;
      @(negedge clk);
      if (i == 7) checkVec("fill full at 8", {wrFull, wrLevel}, {1'b1, 4'd8});
    end
    wrEn = 1'b0;
    checkVec("fill 9th dropped", {wrFull, wrLevel}, {1'b1, 4'd8});

    // Flush mid-frame with a simultaneous write.
    waitState("flush wait send", SEND, 200);
    flush = 1'b1; wrEn = 1'b1; wrData = 8'hEE;
    @(negedge clk);
    flush = 1'b0; wrEn = 1'b0;
    checkVec("flush state drain", dut.state, DRAIN);
    checkVec("flush write dropped", {wrFull, wrLevel}, 5'd0);
    waitState("drain to idle", IDLE, 200);
    checkVec("drain txRun", txIf.txRun, 1'b0);
    repeat (20) @(negedge clk);
    checkVec("drain charDone", doneCnt - dBase, 0);
    checkVec("drain sent", sentQ.size() - sBase, 1);
    checkVec("drain busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end
endmodule
